// File: rtl/dmem_dump_tx.sv
// Data-memory offload engine: stalls the core, reads a block of words through a
// synchronous read port and streams each word out as four UART 8N1 bytes, LSB byte first.
module dmem_dump_tx #(
  parameter int unsigned ADDR_W       = 8,
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] word_count,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_rdata,
  output logic              tx,
  output logic              busy,
  output logic              core_hold,
  output logic              done
);

  localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    StIdle, StFetch, StLatch, StStart, StData, StStop, StFin
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [2:0]        bit_q, bit_d;
  logic [1:0]        byte_q, byte_d;
  logic [31:0]       word_q, word_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W-1:0] remain_q, remain_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              bit_end;

  assign bit_end = (cnt_q == CntMax);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      bit_q    <= '0;
      byte_q   <= '0;
      word_q   <= '0;
      ptr_q    <= '0;
      remain_q <= '0;
      addr_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      byte_q   <= byte_d;
      word_q   <= word_d;
      ptr_q    <= ptr_d;
      remain_q <= remain_d;
      addr_q   <= addr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    byte_d    = byte_q;
    word_d    = word_q;
    ptr_d     = ptr_q;
    remain_d  = remain_q;
    addr_d    = addr_q;
    tx        = 1'b1;
    mem_rd_en = 1'b0;
    done      = 1'b0;

    // One baud counter shared by start, data and stop bits
    if (state_q == StStart || state_q == StData || state_q == StStop) begin
      cnt_d = bit_end ? '0 : cnt_q + CntW'(1);
    end

    unique case (state_q)
      StIdle: begin
        if (start) begin
          ptr_d    = base_addr;
          remain_d = word_count;
          state_d  = (word_count != '0) ? StFetch : StFin;
        end
      end
      StFetch: begin
        mem_rd_en = 1'b1;
        addr_d    = ptr_q;
        state_d   = StLatch;
      end
      StLatch: begin
        word_d   = mem_rdata;
        byte_d   = '0;
        ptr_d    = ptr_q + ADDR_W'(1);
        remain_d = remain_q - ADDR_W'(1);
        cnt_d    = '0;
        state_d  = StStart;
      end
      StStart: begin
        tx = 1'b0;
        if (bit_end) begin
          bit_d   = '0;
          state_d = StData;
        end
      end
      StData: begin
        tx = word_q[{byte_q, bit_q}];
        if (bit_end) begin
          if (bit_q == 3'd7) state_d = StStop;
          else               bit_d   = bit_q + 3'd1;
        end
      end
      StStop: begin
        if (bit_end) begin
          if (byte_q != 2'd3) begin
            byte_d  = byte_q + 2'd1;
            state_d = StStart;
          end else if (remain_q != '0) begin
            state_d = StFetch;
          end else begin
            state_d = StFin;
          end
        end
      end
      StFin: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Address is presented live during FETCH and held afterwards
  assign mem_addr  = (state_q == StFetch) ? ptr_q : addr_q;
  assign busy      = (state_q != StIdle);
  assign core_hold = busy;

endmodule

// File: tb/tb_dmem_dump_tx.sv
// Bench for dmem_dump_tx: per-cycle expected-output queue built from the frame rules,
// plus a UART byte receiver and literal checks on bytes, addresses and timing.
module tb_dmem_dump_tx;

  localparam int C = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  base_addr, word_count, mem_addr;
  logic        mem_rd_en, tx, busy, core_hold, done;
  logic [31:0] mem_rdata = '0;

  dmem_dump_tx #(.ADDR_W(8), .CLKS_PER_BIT(C)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .word_count(word_count), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .tx(tx), .busy(busy), .core_hold(core_hold), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       tx;
    logic       busy;
    logic       done;
    logic       rd;
    logic [7:0] addr;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        e;
  logic [31:0] mem [256];
  logic [7:0]  addr_log[$];
  int          cyc = 0;
  int          first_rd_cyc = -1;
  int          done_cyc = -1;
  int          n_chk = 0;
  int          n_pass = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    else n_pass++;
  endtask

  // Synchronous read port; data is junk whenever no read was issued
  always @(posedge clk) mem_rdata <= mem_rd_en ? mem[mem_addr] : $urandom();

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (reset) begin
      if (mem_rd_en) begin
        addr_log.push_back(mem_addr);
        if (first_rd_cyc < 0) first_rd_cyc = cyc;
      end
      if (done) done_cyc = cyc;
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      chk("reset outputs", {tx, busy, core_hold, done, mem_rd_en, mem_addr}, {5'b10000, 8'h00});
    end else begin
      if (exp_q.size() != 0) e = exp_q.pop_front();
      else                   e = '{tx: 1'b1, busy: 1'b0, done: 1'b0, rd: 1'b0, addr: 8'h00};
      chk("tx/busy/hold/done/rd", {tx, busy, core_hold, done, mem_rd_en},
          {e.tx, e.busy, e.busy, e.done, e.rd});
      if (e.rd) chk("fetch addr", mem_addr, e.addr);
    end
  end

  // Expected cycle-by-cycle outputs of a whole dump, from the frame rules
  task automatic push_dump(input logic [7:0] b, input logic [7:0] n);
    exp_t        x;
    logic [7:0]  p;
    logic [31:0] w;
    p = b;
    for (int k = 0; k < int'(n); k++) begin
      x = '{tx: 1'b1, busy: 1'b1, done: 1'b0, rd: 1'b1, addr: p};
      exp_q.push_back(x);
      x.rd = 1'b0;
      exp_q.push_back(x);
      w = mem[p];
      for (int by = 0; by < 4; by++) begin
        for (int t = 0; t < 10 * C; t++) begin
          if (t < C)            x.tx = 1'b0;
          else if (t >= 9 * C)  x.tx = 1'b1;
          else                  x.tx = w[8 * by + (t / C) - 1];
          exp_q.push_back(x);
        end
      end
      p = p + 8'd1;
    end
    x = '{tx: 1'b1, busy: 1'b1, done: 1'b1, rd: 1'b0, addr: 8'h00};
    exp_q.push_back(x);
  endtask

  task automatic do_start(input logic [7:0] b, input logic [7:0] n);
    first_rd_cyc = -1;
    done_cyc     = -1;
    addr_log.delete();
    @(posedge clk);
    #1 start = 1'b1; base_addr = b; word_count = n;
    @(posedge clk);
    push_dump(b, n);
    #1 start = 1'b0;
  endtask

  task automatic rx_byte(output logic [7:0] b, output bit ok);
    int t;
    b  = '0;
    ok = 1'b0;
    t  = 0;
    while (t < 400 && tx !== 1'b0) begin
      @(negedge clk);
      t++;
    end
    if (t < 400) begin
      repeat (5) @(negedge clk);
      b[0] = tx;
      for (int i = 1; i < 8; i++) begin
        repeat (C) @(negedge clk);
        b[i] = tx;
      end
      repeat (C) @(negedge clk);
      ok = (tx === 1'b1);
    end
  endtask

  task automatic rx_check(input string nm, input logic [7:0] exp);
    logic [7:0] b;
    bit         ok;
    rx_byte(b, ok);
    chk({nm, " byte"}, b, exp);
    chk({nm, " framing"}, ok, 1'b1);
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (done_cyc < 0 && t < 400) begin
      @(negedge clk);
      t++;
    end
    chk("done seen", done_cyc >= 0, 1'b1);
  endtask

  initial begin
    logic [7:0] lit [12];
    reset = 1'b0; start = 1'b0; base_addr = '0; word_count = '0;
    for (int i = 0; i < 256; i++) mem[i] = (i * 32'h0101_0101) ^ 32'hA5A5_0000;
    mem[8'h00] = 32'hDEAD_BEEF;
    mem[8'hFE] = 32'h1122_3344;
    mem[8'hFF] = 32'h5566_7788;
    mem[8'h10] = 32'hCAFE_F00D;

    // Reset state, then idle stability
    repeat (3) @(posedge clk);
    #1;
    chk("rst tx", tx, 1'b1);
    chk("rst busy", busy, 1'b0);
    chk("rst core_hold", core_hold, 1'b0);
    chk("rst done", done, 1'b0);
    chk("rst rd_en", mem_rd_en, 1'b0);
    reset = 1'b1;
    repeat (5) @(posedge clk);

    // Single word DEADBEEF
    do_start(8'h00, 8'd1);
    chk("model length", exp_q.size(), 163);
    chk("model bit0 of EF", exp_q[6].tx, 1'b1);
    chk("model bit4 of EF", exp_q[22].tx, 1'b0);
    rx_check("w0b0", 8'hEF);
    rx_check("w0b1", 8'hBE);
    rx_check("w0b2", 8'hAD);
    rx_check("w0b3", 8'hDE);
    wait_done();
    chk("done latency", done_cyc - first_rd_cyc, 162);
    chk("single read", addr_log.size(), 1);
    repeat (4) @(posedge clk);

    // Zero-length dump
    do_start(8'h05, 8'd0);
    @(negedge clk);
    chk("count0 done", done, 1'b1);
    wait_done();
    chk("count0 no read", addr_log.size(), 0);
    repeat (4) @(posedge clk);

    // Address wrap FE, FF, 00
    lit = '{8'h44, 8'h33, 8'h22, 8'h11, 8'h88, 8'h77, 8'h66, 8'h55,
            8'hEF, 8'hBE, 8'hAD, 8'hDE};
    do_start(8'hFE, 8'd3);
    for (int i = 0; i < 12; i++) rx_check("wrap", lit[i]);
    wait_done();
    chk("wrap reads", addr_log.size(), 3);
    if (addr_log.size() == 3) begin
      chk("wrap addr0", addr_log[0], 8'hFE);
      chk("wrap addr1", addr_log[1], 8'hFF);
      chk("wrap addr2", addr_log[2], 8'h00);
    end
    repeat (4) @(posedge clk);

    // Junk read data after latch, start mid-dump and on FIN both ignored
    do_start(8'h10, 8'd1);
    fork
      begin
        rx_check("cafe0", 8'h0D);
        rx_check("cafe1", 8'hF0);
        rx_check("cafe2", 8'hFE);
        rx_check("cafe3", 8'hCA);
      end
      begin
        repeat (30) @(posedge clk);
        #1 start = 1'b1; base_addr = 8'h40; word_count = 8'd2;
        @(posedge clk);
        #1 start = 1'b0;
      end
    join
    for (int t = 0; t < 400; t++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        break;
      end
    end
    repeat (6) @(posedge clk);
    #1;
    chk("start ignored busy", busy, 1'b0);
    chk("start ignored reads", addr_log.size(), 1);

    // Reset during data bits of byte 2, then a clean restart
    do_start(8'h00, 8'd1);
    rx_check("pre-rst b0", 8'hEF);
    rx_check("pre-rst b1", 8'hBE);
    for (int t = 0; t < 400 && tx !== 1'b0; t++) @(negedge clk);
    repeat (10) @(negedge clk);
    #2 reset = 1'b0;
    exp_q.delete();
    #1;
    chk("midrst tx", tx, 1'b1);
    chk("midrst busy", busy, 1'b0);
    chk("midrst core_hold", core_hold, 1'b0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    do_start(8'hFF, 8'd1);
    rx_check("post-rst b0", 8'h88);
    rx_check("post-rst b1", 8'h77);
    rx_check("post-rst b2", 8'h66);
    rx_check("post-rst b3", 8'h55);
    wait_done();
    repeat (4) @(posedge clk);
    chk("model drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("%0d/%0d checks passed", n_pass, n_chk + 1);
    $fatal(1);
  end

endmodule
